// File: rtl/csr_req_bridge.sv
// csr_req_bridge: queues CPU CSR requests and serialises them onto a sel/ack CSR bus,
// with address-window decode and a per-access ack timeout.
module csr_req_bridge #(
    parameter int             AW    = 16,
    parameter int             DW    = 32,
    parameter int             DEPTH = 2,
    parameter logic [AW-1:0]  BASE  = 16'h0000,
    parameter logic [AW-1:0]  SIZE  = 16'h1000,
    parameter int             TMO   = 64
) (
    input  logic              ref_clk,
    input  logic              sys_rstn,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [AW-1:0]     cpu_req_addr,
    input  logic              cpu_req_we,
    input  logic [DW-1:0]     cpu_req_wdata,
    input  logic [DW/8-1:0]   cpu_req_wstrb,
    output logic              cpu_rsp_valid,
    input  logic              cpu_rsp_ready,
    output logic [DW-1:0]     cpu_rsp_rdata,
    output logic              cpu_rsp_err,
    output logic              csr_sel,
    output logic              csr_we,
    output logic [AW-1:0]     csr_addr,
    output logic [DW-1:0]     csr_wdata,
    output logic [DW/8-1:0]   csr_wstrb,
    input  logic              csr_ack,
    input  logic [DW-1:0]     csr_rdata,
    input  logic              csr_err,
    output logic              busy
);
    localparam int SW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TMO);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   fa_q [DEPTH];
    logic            fw_q [DEPTH];
    logic [DW-1:0]   fd_q [DEPTH];
    logic [SW-1:0]   fs_q [DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic [PW:0]     fill_q, fill_d;
    logic            ready_q;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic            sel_q, sel_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            push, pop, hit;
    logic [AW:0]     off;

    assign push = cpu_req_valid && ready_q;
    // Offset from BASE at AW+1 bits: an address below BASE borrows into the top bit and
    // lands above SIZE, and a window ending exactly at 2^AW cannot wrap.
    assign off  = {1'b0, fa_q[rp_q]} - {1'b0, BASE};
    assign hit  = off < {1'b0, SIZE};

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: if (fill_q != '0) begin
                pop = 1'b1;
                if (hit) begin
                    sel_d   = 1'b1;
                    we_d    = fw_q[rp_q];
                    addr_d  = fa_q[rp_q];
                    wdata_d = fd_q[rp_q];
                    wstrb_d = fs_q[rp_q];
                    tmo_d   = '0;
                    state_d = ISSUE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end
            end
            ISSUE: if (csr_ack) begin
                sel_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = csr_err;
                rsp_rdata_d = we_q ? '0 : csr_rdata;
                state_d     = RESP;
            end else if (tmo_q == CW'(TMO - 1)) begin
                sel_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                state_d     = RESP;
            end else begin
                tmo_d = tmo_q + CW'(1);
            end
            RESP: if (cpu_rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        fill_d = fill_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge ref_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            fill_q      <= '0;
            ready_q     <= 1'b0;
            tmo_q       <= '0;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= push ? wp_q + PW'(1) : wp_q;
            rp_q        <= pop ? rp_q + PW'(1) : rp_q;
            fill_q      <= fill_d;
            ready_q     <= fill_d != (PW+1)'(DEPTH);
            tmo_q       <= tmo_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (push) begin
            fa_q[wp_q] <= cpu_req_addr;
            fw_q[wp_q] <= cpu_req_we;
            fd_q[wp_q] <= cpu_req_wdata;
            fs_q[wp_q] <= cpu_req_wstrb;
        end
    end

    assign cpu_req_ready = ready_q;
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_err   = rsp_err_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign csr_sel       = sel_q;
    assign csr_we        = we_q;
    assign csr_addr      = addr_q;
    assign csr_wdata     = wdata_q;
    assign csr_wstrb     = wstrb_q;
    assign busy          = (fill_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_csr_req_bridge.sv
// tb_csr_req_bridge: directed scenario tests for csr_req_bridge with hand-computed expectations.
module tb_csr_req_bridge;
    logic        ref_clk, sys_rstn;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [15:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic [3:0]  cpu_req_wstrb;
    logic        cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
    logic [31:0] cpu_rsp_rdata;
    logic        csr_sel, csr_we;
    logic [15:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [3:0]  csr_wstrb;
    logic        csr_ack, csr_err;
    logic [31:0] csr_rdata;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    csr_req_bridge dut (
        .ref_clk(ref_clk), .sys_rstn(sys_rstn),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
        .csr_sel(csr_sel), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err),
        .busy(busy)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge ref_clk);
        #1;
    endtask

    task automatic req(input logic [15:0] a, input logic we, input logic [31:0] d);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_we    = we;
        cpu_req_wdata = d;
        cpu_req_wstrb = 4'hF;
    endtask

    task automatic take_rsp;
        cpu_rsp_ready = 1'b1;
        tick;
        cpu_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (csr_sel !== 1'b0) begin errors++; $display("FAIL rst_sel got=%b exp=0", csr_sel); end
        checks++; if (cpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", cpu_rsp_valid); end
        checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cpu_req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if ({cpu_rsp_err, cpu_rsp_rdata} !== 33'h0) begin errors++; $display("FAIL rst_rsp got=%h exp=0", {cpu_rsp_err, cpu_rsp_rdata}); end
        tick;
        tick;
        sys_rstn = 1'b1;
        tick;
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", cpu_req_ready); end
    endtask

    task automatic test_write;
        req(16'h0010, 1'b1, 32'hA5A5_0001);
        tick;
        cpu_req_valid = 1'b0;
        checks++; if (csr_sel !== 1'b0) begin errors++; $display("FAIL wr_sel_c1 got=%b exp=0", csr_sel); end
        tick;
        checks++; if (csr_sel !== 1'b1) begin errors++; $display("FAIL wr_sel_c2 got=%b exp=1", csr_sel); end
        checks++; if ({csr_we, csr_addr, csr_wdata, csr_wstrb} !== {1'b1, 16'h0010, 32'hA5A5_0001, 4'hF})
            begin errors++; $display("FAIL wr_fields got=%b/%h/%h/%h exp=1/0010/a5a50001/f", csr_we, csr_addr, csr_wdata, csr_wstrb); end
        tick;
        tick;
        checks++; if ({csr_sel, csr_addr, csr_wdata} !== {1'b1, 16'h0010, 32'hA5A5_0001})
            begin errors++; $display("FAIL wr_hold got=%b/%h/%h exp=1/0010/a5a50001", csr_sel, csr_addr, csr_wdata); end
        tick;
        csr_ack = 1'b1; csr_rdata = 32'hDEAD_BEEF; csr_err = 1'b0;
        tick;
        csr_ack = 1'b0;
        checks++; if (csr_sel !== 1'b0) begin errors++; $display("FAIL wr_sel_drop got=%b exp=0", csr_sel); end
        checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b0, 32'h0})
            begin errors++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/00000000", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
        take_rsp;
        checks++; if (cpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_clear got=%b exp=0", cpu_rsp_valid); end
    endtask

    task automatic test_read_decode;
        int sel_seen;
        req(16'h0FFC, 1'b0, 32'h0);
        tick;
        cpu_req_valid = 1'b0;
        tick;
        checks++; if ({csr_sel, csr_we, csr_addr} !== {1'b1, 1'b0, 16'h0FFC})
            begin errors++; $display("FAIL rd_issue got=%b/%b/%h exp=1/0/0ffc", csr_sel, csr_we, csr_addr); end
        csr_ack = 1'b1; csr_rdata = 32'h1234_5678; csr_err = 1'b0;
        tick;
        csr_ack = 1'b0;
        checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b0, 32'h1234_5678})
            begin errors++; $display("FAIL rd_rsp got=%b/%b/%h exp=1/0/12345678", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
        take_rsp;
        req(16'h1000, 1'b0, 32'h0);
        sel_seen = 0;
        tick;
        cpu_req_valid = 1'b0;
        sel_seen += int'(csr_sel);
        checks++; if (cpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL dec_early got=%b exp=0", cpu_rsp_valid); end
        tick;
        sel_seen += int'(csr_sel);
        checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b1, 32'h0})
            begin errors++; $display("FAIL dec_rsp got=%b/%b/%h exp=1/1/00000000", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
        take_rsp;
        sel_seen += int'(csr_sel);
        checks++; if (sel_seen !== 0) begin errors++; $display("FAIL dec_no_sel got=%0d exp=0", sel_seen); end
    endtask

    task automatic test_timeout;
        int hi;
        int extra;
        req(16'h0020, 1'b0, 32'h0);
        tick;
        cpu_req_valid = 1'b0;
        tick;
        hi = 0;
        for (int i = 0; i < 100 && csr_sel; i++) begin
            hi++;
            tick;
        end
        checks++; if (hi !== 64) begin errors++; $display("FAIL tmo_sel_len got=%0d exp=64", hi); end
        checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b1, 32'h0})
            begin errors++; $display("FAIL tmo_rsp got=%b/%b/%h exp=1/1/00000000", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
        repeat (5) tick;
        csr_ack = 1'b1; csr_rdata = 32'hFFFF_FFFF; csr_err = 1'b0;
        tick;
        csr_ack = 1'b0;
        checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b1, 32'h0})
            begin errors++; $display("FAIL tmo_late_ack got=%b/%b/%h exp=1/1/00000000", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
        take_rsp;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            extra += int'(cpu_rsp_valid) + int'(csr_sel);
            tick;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL tmo_no_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_addr [3];
        int k;
        exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0104; exp_addr[2] = 16'h0108;
        for (int i = 0; i < 3; i++) begin
            req(exp_addr[i], 1'b0, 32'h0);
            tick;
        end
        req(16'h010C, 1'b0, 32'h0);
        checks++; if (cpu_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got=%b exp=0", cpu_req_ready); end
        tick;
        tick;
        checks++; if ({cpu_req_ready, busy, csr_sel, csr_addr} !== {1'b0, 1'b1, 1'b1, 16'h0100})
            begin errors++; $display("FAIL b2b_stall got=%b/%b/%b/%h exp=0/1/1/0100", cpu_req_ready, busy, csr_sel, csr_addr); end
        cpu_req_valid = 1'b0;
        csr_ack = 1'b1; csr_rdata = 32'hC0DE_0100; csr_err = 1'b0;
        tick;
        csr_ack = 1'b0;
        checks++; if ({cpu_req_ready, cpu_rsp_valid} !== 2'b01)
            begin errors++; $display("FAIL b2b_held got=%b/%b exp=0/1", cpu_req_ready, cpu_rsp_valid); end
        cpu_rsp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 200 && k < 3; i++) begin
            if (cpu_rsp_valid) begin
                checks++;
                if ({cpu_rsp_err, cpu_rsp_rdata} !== {1'b0, 16'hC0DE, exp_addr[k]})
                    begin errors++; $display("FAIL b2b_rsp%0d got=%b/%h exp=0/c0de%h", k, cpu_rsp_err, cpu_rsp_rdata, exp_addr[k]); end
                k++;
            end
            csr_ack   = csr_sel && !csr_ack;
            csr_rdata = {16'hC0DE, csr_addr};
            tick;
        end
        csr_ack = 1'b0;
        cpu_rsp_ready = 1'b0;
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", k); end
        checks++; if ({busy, cpu_rsp_valid, cpu_req_ready} !== 3'b001)
            begin errors++; $display("FAIL b2b_idle got=%b/%b/%b exp=0/0/1", busy, cpu_rsp_valid, cpu_req_ready); end
    endtask

    task automatic test_ack_at_expiry;
        req(16'h0200, 1'b0, 32'h0);
        tick;
        cpu_req_valid = 1'b0;
        tick;
        repeat (63) tick;
        checks++; if (csr_sel !== 1'b1) begin errors++; $display("FAIL exp_sel got=%b exp=1", csr_sel); end
        csr_ack = 1'b1; csr_rdata = 32'hCAFE_F00D; csr_err = 1'b1;
        tick;
        csr_ack = 1'b0; csr_err = 1'b0;
        checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b1, 32'hCAFE_F00D})
            begin errors++; $display("FAIL exp_rsp got=%b/%b/%h exp=1/1/cafef00d", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
        take_rsp;
    endtask

    task automatic test_reset_mid;
        int seen;
        req(16'h0300, 1'b0, 32'h0);
        tick;
        req(16'h0304, 1'b0, 32'h0);
        tick;
        cpu_req_valid = 1'b0;
        tick;
        checks++; if ({csr_sel, busy} !== 2'b11) begin errors++; $display("FAIL rm_pre got=%b/%b exp=1/1", csr_sel, busy); end
        sys_rstn = 1'b0;
        #1;
        checks++; if ({csr_sel, busy, cpu_rsp_valid} !== 3'b000)
            begin errors++; $display("FAIL rm_async got=%b/%b/%b exp=0/0/0", csr_sel, busy, cpu_rsp_valid); end
        tick;
        tick;
        sys_rstn = 1'b1;
        tick;
        checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%b exp=1", cpu_req_ready); end
        cpu_rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            seen += int'(cpu_rsp_valid) + int'(csr_sel) + int'(busy);
            tick;
        end
        cpu_rsp_ready = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL rm_quiet got=%0d exp=0", seen); end
    endtask

    initial begin
        sys_rstn = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_we = 1'b0;
        cpu_req_wdata = '0; cpu_req_wstrb = '0; cpu_rsp_ready = 1'b0;
        csr_ack = 1'b0; csr_rdata = '0; csr_err = 1'b0;
        test_reset;
        test_write;
        test_read_decode;
        test_timeout;
        test_back_to_back;
        test_ack_at_expiry;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
